// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: pipeline load enables, NOP/flush control and one-entry fetch skid buffer
module pipeline_flow_ctrl #(
    parameter int CNT_WIDTH = 16,
    parameter int IR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gen_bubble,
    input  logic                 squash_ID,
    input  logic                 imem_resp,
    input  logic [IR_WIDTH-1:0]  imem_rdata,
    input  logic                 dmem_access,
    input  logic                 dmem_resp,
    output logic                 imem_read,
    output logic [IR_WIDTH-1:0]  if_ir,
    output logic                 flow_IF,
    output logic                 flow_ID_EX,
    output logic                 flow_EX_MEM,
    output logic                 flow_MEM_WB,
    output logic                 insert_nop,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] bubble_count
);
    typedef enum logic {FETCH, BUFFERED} state_t;
    state_t state, state_nx;
    logic if_id_valid, if_id_valid_nx, buf_valid, mem_stall, fetch_ready;
    logic [IR_WIDTH-1:0] buf_ir;
    always_comb begin
        buf_valid      = state == BUFFERED;
        mem_stall      = dmem_access & ~dmem_resp;
        fetch_ready    = imem_resp | buf_valid;
        flow_ID_EX     = rst_n & ~mem_stall;
        flow_EX_MEM    = flow_ID_EX;
        flow_MEM_WB    = flow_ID_EX;
        flow_IF        = flow_ID_EX & fetch_ready & (squash_ID | ~gen_bubble);
        insert_nop     = flow_ID_EX & (squash_ID | gen_bubble | ~if_id_valid);
        imem_read      = rst_n & ~buf_valid;
        if_ir          = buf_valid ? buf_ir : imem_rdata;
        if_id_valid_nx = mem_stall ? if_id_valid : flow_IF ? 1'b1 :
                         (gen_bubble & ~squash_ID) ? if_id_valid : 1'b0;
        state_nx       = state;
        if (state == FETCH && imem_resp && !flow_IF && !squash_ID)
            state_nx = BUFFERED;
        else if (state == BUFFERED && (flow_IF || squash_ID))
            state_nx = FETCH;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            if_id_valid  <= 1'b0;
            buf_ir       <= '0;
            stall_cycles <= '0;
            bubble_count <= '0;
        end else begin
            state       <= state_nx;
            if_id_valid <= if_id_valid_nx;
            if (state == FETCH && state_nx == BUFFERED)
                buf_ir <= imem_rdata;
            if (!flow_IF && !(&stall_cycles))
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (insert_nop && !(&bubble_count))
                bubble_count <= bubble_count + CNT_WIDTH'(1);
        end
    end
endmodule
